// File: rtl/dot_matrix_scanner.sv
// dot_matrix_scanner
//   Row-scan controller for an LED dot-matrix display with a double-buffered
//   frame store. The host writes row patterns into the back bank; a swap
//   request exchanges front/back only when the scan wraps to row 0, so a
//   frame is never shown torn. One active-low row is driven at a time,
//   together with that row's column pattern, and each row is held for
//   SCAN_DIV clock cycles.
//
//   Optional build macro DOT_BLANK_EN: when defined, the first BLANK_CYC
//   cycles of every row dwell are blanked (all rows off, columns zero).
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   wr_en       write wr_data into back bank at wr_row this cycle
//   wr_row      target row for the write (values >= ROWS are ignored)
//   wr_data     column pattern, bit c = column c lit
//   swap_req    level request to exchange banks at the next frame boundary
//   swap_ack    one-cycle pulse in the cycle the banks exchange
//   frame_start one-cycle pulse when the scan wraps to row 0
//   dot_row     row select, active-low, at most one bit low
//   dot_column  column data for the selected row, active-high
module dot_matrix_scanner #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int SCAN_DIV  = 2500,
  parameter int BLANK_CYC = 16,
  localparam int RW       = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  output logic            swap_ack,
  output logic            frame_start,
  output logic [ROWS-1:0] dot_row,
  output logic [COLS-1:0] dot_column
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

`ifdef DOT_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic [PW-1:0]   prescaler;
  logic [PW-1:0]   prescaler_nxt;
  logic [RW-1:0]   row_idx;
  logic [RW-1:0]   row_nxt;
  logic            front_sel;
  logic [COLS-1:0] bank [2][ROWS];

  logic            row_tick;
  logic            frame_wrap;
  logic            do_swap;
  logic            wr_ok;
  logic            blank;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] front_data;

  always_comb begin
    row_tick      = 1'b0;
    frame_wrap    = 1'b0;
    do_swap       = 1'b0;
    wr_ok         = 1'b0;
    blank         = 1'b0;
    prescaler_nxt = prescaler;
    row_nxt       = row_idx;
    row_sel       = '1;
    front_data    = '0;

    row_tick   = (prescaler == PW'(SCAN_DIV - 1));
    frame_wrap = row_tick && (row_idx == RW'(ROWS - 1));
    do_swap    = frame_wrap && swap_req;
    wr_ok      = wr_en && (int'(wr_row) < ROWS);

    prescaler_nxt = row_tick ? '0 : prescaler + 1'b1;
    if (row_tick) begin
      row_nxt = frame_wrap ? '0 : row_idx + 1'b1;
    end

    // Blanking keys off the prescaler value of the cycle being registered,
    // so the blank window lines up with the 1-cycle output latency.
    blank = BLANK_ON && (int'(prescaler) < BLANK_CYC);

    row_sel    = ~(ROWS'(1) << row_idx);
    front_data = bank[front_sel][row_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler   <= '0;
      row_idx     <= '0;
      front_sel   <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      dot_row     <= '1;
      dot_column  <= '0;
    end else begin
      prescaler   <= prescaler_nxt;
      row_idx     <= row_nxt;
      swap_ack    <= do_swap;
      frame_start <= frame_wrap;
      if (do_swap) begin
        front_sel <= ~front_sel;
      end
      if (blank) begin
        dot_row    <= '1;
        dot_column <= '0;
      end else begin
        dot_row    <= row_sel;
        dot_column <= front_data;
      end
    end
  end

  // The back bank is selected with the pre-swap front_sel, so a write on the
  // swap edge lands in the bank that becomes front on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          bank[b][r] <= '0;
        end
      end
    end else if (wr_ok) begin
      bank[~front_sel][wr_row] <= wr_data;
    end
  end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// tb_dot_matrix_scanner
//   Two scanner instances: A (8 rows, 8 cols, SCAN_DIV=4) and B (5 rows,
//   8 cols, SCAN_DIV=2). A frame-level model predicts every output from a
//   cycle count since reset and a pair of front/back arrays that are
//   exchanged on swaps; outputs are compared on each falling edge.
module tb_dot_matrix_scanner;

  localparam int AR = 8;
  localparam int AD = 4;
  localparam int BR = 5;
  localparam int BD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       wen   [2];
  logic [2:0] wrow  [2];
  logic [7:0] wdata [2];
  logic       sreq  [2];

  logic [7:0] drow_a;
  logic [4:0] drow_b;
  logic [7:0] dcol_a, dcol_b;
  logic       ack_a, ack_b, fs_a, fs_b;

  dot_matrix_scanner #(.ROWS(AR), .COLS(8), .SCAN_DIV(AD), .BLANK_CYC(2)) u_a (
    .clk(clk), .reset(rst[0]), .wr_en(wen[0]), .wr_row(wrow[0]),
    .wr_data(wdata[0]), .swap_req(sreq[0]), .swap_ack(ack_a),
    .frame_start(fs_a), .dot_row(drow_a), .dot_column(dcol_a)
  );

  dot_matrix_scanner #(.ROWS(BR), .COLS(8), .SCAN_DIV(BD), .BLANK_CYC(1)) u_b (
    .clk(clk), .reset(rst[1]), .wr_en(wen[1]), .wr_row(wrow[1]),
    .wr_data(wdata[1]), .swap_req(sreq[1]), .swap_ack(ack_b),
    .frame_start(fs_b), .dot_row(drow_b), .dot_column(dcol_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s act=timeout exp=event", nm);
  endtask

  // ---------------- frame-level model ----------------
  int         rows_p [2] = '{AR, BR};
  int         div_p  [2] = '{AD, BD};
  int         e_cnt  [2];
  logic [7:0] mfront [2][8];
  logic [7:0] mback  [2][8];
  logic [7:0] x_row  [2];
  logic [7:0] x_col  [2];
  logic       x_ack  [2];
  logic       x_fs   [2];
  bit         mvalid [2] = '{1'b0, 1'b0};

  task automatic model_step(input int k);
    int         r;
    bit         wrap;
    logic [7:0] mask;
    logic [7:0] tmp;
    mask = 8'((1 << rows_p[k]) - 1);
    if (rst[k]) begin
      e_cnt[k] = 0;
      for (int i = 0; i < 8; i++) begin
        mfront[k][i] = '0;
        mback[k][i]  = '0;
      end
      x_row[k] = mask;
      x_col[k] = '0;
      x_ack[k] = 1'b0;
      x_fs[k]  = 1'b0;
    end else begin
      r        = (e_cnt[k] / div_p[k]) % rows_p[k];
      x_row[k] = ~(8'd1 << r) & mask;
      x_col[k] = mfront[k][r];
      wrap     = ((e_cnt[k] + 1) % (div_p[k] * rows_p[k])) == 0;
      if (wen[k] && (int'(wrow[k]) < rows_p[k])) mback[k][wrow[k]] = wdata[k];
      x_fs[k]  = wrap;
      x_ack[k] = wrap && sreq[k];
      if (x_ack[k]) begin
        for (int i = 0; i < 8; i++) begin
          tmp          = mfront[k][i];
          mfront[k][i] = mback[k][i];
          mback[k][i]  = tmp;
        end
      end
      e_cnt[k]++;
    end
    mvalid[k] = 1'b1;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (mvalid[0]) begin
      chk("a_row", {24'd0, drow_a}, {24'd0, x_row[0]});
      chk("a_col", {24'd0, dcol_a}, {24'd0, x_col[0]});
      chk("a_ack", {31'd0, ack_a}, {31'd0, x_ack[0]});
      chk("a_fs",  {31'd0, fs_a},  {31'd0, x_fs[0]});
    end
    if (mvalid[1]) begin
      chk("b_row", {27'd0, drow_b}, {24'd0, x_row[1]});
      chk("b_col", {24'd0, dcol_b}, {24'd0, x_col[1]});
      chk("b_ack", {31'd0, ack_b}, {31'd0, x_ack[1]});
      chk("b_fs",  {31'd0, fs_b},  {31'd0, x_fs[1]});
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit seen;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; wen[k] = 1'b0; wrow[k] = '0; wdata[k] = '0; sreq[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_row_a", {24'd0, drow_a}, 32'hFF);
    chk("rst_col_a", {24'd0, dcol_a}, 32'h0);
    chk("rst_row_b", {27'd0, drow_b}, 32'h1F);
    chk("rst_fs_a",  {31'd0, fs_a},   32'h0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Empty scan: row walk and frame pulse timing.
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("first_row_a", {24'd0, drow_a}, 32'hFE);
        chk("first_row_b", {27'd0, drow_b}, 32'h1E);
      end
      if (i == 5)  chk("row1_a", {24'd0, drow_a}, 32'hFD);
      if (i == 9)  chk("row4_b", {27'd0, drow_b}, 32'h0F);
      if (i == 11) chk("wrap_b", {27'd0, drow_b}, 32'h1E);
      if (i == 31) chk("fs_pre_a", {31'd0, fs_a}, 32'h0);
      if (i == 32) chk("fs_wrap_a", {31'd0, fs_a}, 32'h1);
    end

    // Fill back bank of A, request swap mid-frame.
    wen[0] = 1'b1; wrow[0] = 3'd0; wdata[0] = 8'h18;
    @(negedge clk);
    wrow[0] = 3'd7; wdata[0] = 8'h7E;
    @(negedge clk);
    wen[0] = 1'b0;
    sreq[0] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 80 && !seen; n++) begin
      @(negedge clk);
      seen = ack_a;
    end
    if (!seen) timeout("swap1_a");
    chk("ack_with_fs_a", {31'd0, fs_a}, 32'h1);
    sreq[0] = 1'b0;
    @(negedge clk);
    chk("swap1_row0_col", {24'd0, dcol_a}, 32'h18);
    chk("swap1_row0_sel", {24'd0, drow_a}, 32'hFE);

    // Second swap with a write on the exact swap edge.
    sreq[0] = 1'b1;
    repeat (30) @(negedge clk);
    wen[0] = 1'b1; wrow[0] = 3'd3; wdata[0] = 8'hFF;
    @(negedge clk);
    wen[0] = 1'b0;
    chk("swap2_ack_a", {31'd0, ack_a}, 32'h1);
    sreq[0] = 1'b0;
    repeat (13) @(negedge clk);
    chk("swap2_row3_col", {24'd0, dcol_a}, 32'hFF);
    chk("swap2_row3_sel", {24'd0, drow_a}, 32'hF7);

    // B: out-of-range writes are ignored, in-range write then swap.
    wen[1] = 1'b1; wrow[1] = 3'd6; wdata[1] = 8'hAA;
    @(negedge clk);
    wrow[1] = 3'd7; wdata[1] = 8'h5A;
    @(negedge clk);
    wrow[1] = 3'd2; wdata[1] = 8'h55;
    @(negedge clk);
    wen[1] = 1'b0;
    sreq[1] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = ack_b;
    end
    if (!seen) timeout("swap_b");
    sreq[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("b_row2_col", {24'd0, dcol_b}, 32'h55);
    chk("b_row2_sel", {27'd0, drow_b}, 32'h1B);
    repeat (12) @(negedge clk);

    // A: reset while row 5 is lit with a pending swap request.
    seen = 1'b0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      seen = (drow_a == 8'hDF);
    end
    if (!seen) timeout("find_row5_a");
    sreq[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_row_a", {24'd0, drow_a}, 32'hFF);
    chk("midrst_col_a", {24'd0, dcol_a}, 32'h0);
    chk("midrst_ack_a", {31'd0, ack_a},  32'h0);
    rst[0] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      seen = ack_a;
    end
    if (!seen) timeout("swap_after_rst_a");
    sreq[0] = 1'b0;
    @(negedge clk);
    chk("post_rst_row0_col", {24'd0, dcol_a}, 32'h0);
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
